// File: rtl/mult_arbiter_if.sv
// Operand-request and result handshake bundle for mult_arbiter.
// The requester/consumer side uses the master modport; the arbiter uses slave.
interface mult_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [18*NREQ-1:0]   req_a;
   logic [18*NREQ-1:0]   req_b;
   logic                 res_valid;
   logic                 res_ready;
   logic [IDW-1:0]       res_id;
   logic signed [35:0]   res_p;

   modport master (
      output req_valid, req_a, req_b, res_ready,
      input  req_ready, res_valid, res_id, res_p
   );

   modport slave (
      input  req_valid, req_a, req_b, res_ready,
      output req_ready, res_valid, res_id, res_p
   );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one 3-cycle 18x18 signed multiplier with id/valid tag tracking
// and whole-pipeline stall on result backpressure. Define MULT_ARB_STATS_EN for op/stall counters.

module mult18x18_3c (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic signed [17:0] a,
   input  logic signed [17:0] b,
   output logic signed [35:0] p
);
   logic signed [17:0] a_p0, b_p0;
   logic signed [35:0] prod_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         a_p0    <= '0;
         b_p0    <= '0;
         prod_p1 <= '0;
         p       <= '0;
      end else if (en) begin
         // p0: operand capture
         a_p0    <= a;
         b_p0    <= b;
         // p1: multiply
         prod_p1 <= a_p0 * b_p0;
         // p2: output register
         p       <= prod_p1;
      end
   end
endmodule

module mult_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int LAT  = 3
) (
   input  logic          clk,
   input  logic          rst,
   mult_arbiter_if.slave bus,
   input  logic          stat_clr,
   output logic [31:0]   stat_ops,
   output logic [31:0]   stat_stall
);
   localparam int             KW     = IDW + 1;
   localparam logic [IDW:0]   NREQ_W = NREQ[IDW:0];

   logic [IDW-1:0]     rr;
   logic [IDW-1:0]     win;
   logic [IDW-1:0]     rr_nxt;
   logic [IDW:0]       idx_w;
   logic [IDW:0]       inc_w;
   logic               found;
   logic               en;
   logic               accept;
   logic signed [17:0] mul_a, mul_b;
   logic               tag_vld_p [LAT];
   logic [IDW-1:0]     tag_id_p  [LAT];

   assign en = !(tag_vld_p[LAT-1] && !bus.res_ready);

   // First asserted request at or after the pointer, wrapping modulo NREQ.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx_w = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx_w = {1'b0, rr} + KW'(k);
         if (idx_w >= NREQ_W) idx_w = idx_w - NREQ_W;
         if (!found && bus.req_valid[idx_w[IDW-1:0]]) begin
            found = 1'b1;
            win   = idx_w[IDW-1:0];
         end
      end
   end

   assign accept = found && en && !rst;

   always_comb begin
      bus.req_ready = '0;
      if (accept) bus.req_ready[win] = 1'b1;
   end

   always_comb begin
      inc_w  = {1'b0, win} + KW'(1);
      rr_nxt = (inc_w == NREQ_W) ? '0 : inc_w[IDW-1:0];
   end

   assign mul_a = accept ? $signed(bus.req_a[18*win +: 18]) : '0;
   assign mul_b = accept ? $signed(bus.req_b[18*win +: 18]) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         rr <= '0;
      end else if (accept) begin
         rr <= rr_nxt;
      end
   end

   // Tag pipeline mirrors the multiplier stages and freezes with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < LAT; k++) begin
            tag_vld_p[k] <= 1'b0;
            tag_id_p[k]  <= '0;
         end
      end else if (en) begin
         tag_vld_p[0] <= accept;
         tag_id_p[0]  <= win;
         for (int k = 1; k < LAT; k++) begin
            tag_vld_p[k] <= tag_vld_p[k-1];
            tag_id_p[k]  <= tag_id_p[k-1];
         end
      end
   end

   assign bus.res_valid = tag_vld_p[LAT-1];
   assign bus.res_id    = tag_id_p[LAT-1];

   mult18x18_3c u_mult (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .a   (mul_a),
      .b   (mul_b),
      .p   (bus.res_p)
   );

`ifdef MULT_ARB_STATS_EN
   logic [31:0] ops_q, stall_q;

   // A clear takes priority over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (rst || stat_clr) begin
         ops_q   <= '0;
         stall_q <= '0;
      end else begin
         if (tag_vld_p[LAT-1] && bus.res_ready) ops_q <= ops_q + 32'd1;
         if (!en) stall_q <= stall_q + 32'd1;
      end
   end

   assign stat_ops   = ops_q;
   assign stat_stall = stall_q;
`else
   logic unused_stat_clr;
   assign unused_stat_clr = stat_clr;
   assign stat_ops        = '0;
   assign stat_stall      = '0;
`endif
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: single-op vector table plus round-robin,
// backpressure, mid-flight reset and statistics sequences.
module tb_mult_arbiter;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stat_clr = 1'b0;
   logic [31:0] stat_ops, stat_stall;
   int          nvec = 0;
   int          nerr = 0;

   mult_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   mult_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus.slave),
      .stat_clr   (stat_clr),
      .stat_ops   (stat_ops),
      .stat_stall (stat_stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                 req;
      logic signed [17:0] a;
      logic signed [17:0] b;
      logic signed [35:0] p;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string nm, input logic signed [63:0] got, input logic signed [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   task automatic set_op(input int i, input logic signed [17:0] a, input logic signed [17:0] b);
      bus.req_a[18*i +: 18] = a;
      bus.req_b[18*i +: 18] = b;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.req_valid = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] m;
      int         acc;
      int         eid;

      vecs[0] = '{0, 18'sd3,       -18'sd5,      -36'sd15};
      vecs[1] = '{1, -18'sd131072, -18'sd131072, 36'sh4_0000_0000};
      vecs[2] = '{2, 18'sd131071,  -18'sd131072, -36'sd17179738112};
      vecs[3] = '{3, 18'sd0,       18'sd12345,   36'sd0};
      vecs[4] = '{1, -18'sd1,      -18'sd1,      36'sd1};
      vecs[5] = '{2, 18'sd100,     -18'sd200,    -36'sd20000};
      vecs[6] = '{0, 18'sd131071,  18'sd131071,  36'sd17179607041};

      bus.req_valid = 4'hF;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.res_ready = 1'b1;

      // Reset state, with every requester asserting.
      step(); step(); step();
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_res_id",    bus.res_id, 0);
      chk("rst_res_p",     $signed(bus.res_p), 0);
      chk("rst_stat_ops",  stat_ops, 0);
      chk("rst_stat_stall", stat_stall, 0);
      bus.req_valid = '0;
      rst = 1'b0;
      step();

      // Single isolated ops: grant, 3-cycle latency, one-cycle result.
      for (int v = 0; v < 7; v++) begin
         m = 4'(1 << vecs[v].req);
         set_op(vecs[v].req, vecs[v].a, vecs[v].b);
         bus.req_valid = m;
         #1;
         chk($sformatf("v%0d_req_ready", v), bus.req_ready, m);
         step();
         bus.req_valid = '0;
         chk($sformatf("v%0d_early_valid", v), bus.res_valid, 0);
         step();
         step();
         chk($sformatf("v%0d_res_valid", v), bus.res_valid, 1);
         chk($sformatf("v%0d_res_id", v), bus.res_id, vecs[v].req);
         chk($sformatf("v%0d_res_p", v), $signed(bus.res_p), vecs[v].p);
         step();
         chk($sformatf("v%0d_res_gone", v), bus.res_valid, 0);
      end

      // Round robin with all four requesters continuously valid.
      do_reset();
      for (int i = 0; i < NREQ; i++) set_op(i, 18'(i + 1), 18'sd10);
      for (int c = 0; c < 11; c++) begin
         bus.req_valid = (c < 8) ? 4'hF : 4'h0;
         #1;
         chk($sformatf("rr_c%0d_ready", c), bus.req_ready, (c < 8) ? (1 << (c % 4)) : 0);
         if (c >= 3) begin
            chk($sformatf("rr_c%0d_valid", c), bus.res_valid, 1);
            chk($sformatf("rr_c%0d_id", c), bus.res_id, (c - 3) % 4);
            chk($sformatf("rr_c%0d_p", c), $signed(bus.res_p), 10 * ((c - 3) % 4 + 1));
         end else begin
            chk($sformatf("rr_c%0d_valid", c), bus.res_valid, 0);
         end
         step();
      end

      // Backpressure: consumer stalls for 5 cycles while a result is waiting.
      do_reset();
      for (int i = 0; i < NREQ; i++) set_op(i, 18'(i + 1), -18'sd7);
      for (int c = 0; c < 13; c++) begin
         bus.req_valid = (c <= 8) ? 4'hF : 4'h0;
         bus.res_ready = !(c >= 4 && c <= 8);
         #1;
         chk($sformatf("bp_c%0d_ready", c), bus.req_ready, (c < 4) ? (1 << c) : 0);
         if (c == 3) eid = 0;
         else if (c >= 4 && c <= 9) eid = 1;
         else if (c == 10) eid = 2;
         else if (c == 11) eid = 3;
         else eid = -1;
         chk($sformatf("bp_c%0d_valid", c), bus.res_valid, (eid >= 0) ? 1 : 0);
         if (eid >= 0) begin
            chk($sformatf("bp_c%0d_id", c), bus.res_id, eid);
            chk($sformatf("bp_c%0d_p", c), $signed(bus.res_p), -7 * (eid + 1));
         end
         step();
      end
      bus.res_ready = 1'b1;

      // Reset with two ops in flight; pointer must return to 0.
      do_reset();
      set_op(0, 18'sd5, 18'sd5);
      set_op(1, 18'sd6, 18'sd6);
      set_op(2, 18'sd7, 18'sd7);
      bus.req_valid = 4'b0001;
      step();
      bus.req_valid = 4'b0010;
      step();
      bus.req_valid = 4'b0000;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("mr_c%0d_valid", c), bus.res_valid, 0);
         step();
      end
      bus.req_valid = 4'b0101;
      #1;
      chk("mr_first_grant", bus.req_ready, 4'b0001);
      step();
      chk("mr_second_grant", bus.req_ready, 4'b0100);
      bus.req_valid = '0;
      step(); step(); step(); step();

`ifdef MULT_ARB_STATS_EN
      do_reset();
      chk("st_init_ops", stat_ops, 0);
      chk("st_init_stall", stat_stall, 0);
      acc = 0;
      for (int c = 0; c < 40; c++) begin
         bus.req_valid = (acc < 6) ? 4'b0001 : 4'b0000;
         set_op(0, 18'(c), 18'sd2);
         bus.res_ready = !(c >= 3 && c <= 7);
         #1;
         if (bus.req_valid[0] && bus.req_ready[0]) acc++;
         step();
      end
      bus.res_ready = 1'b1;
      chk("st_accepts", acc, 6);
      chk("st_ops", stat_ops, 6);
      chk("st_stall", stat_stall, 5);
      stat_clr = 1'b1;
      step();
      stat_clr = 1'b0;
      chk("st_clr_ops", stat_ops, 0);
      chk("st_clr_stall", stat_stall, 0);
`else
      chk("st_off_ops", stat_ops, 0);
      chk("st_off_stall", stat_stall, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one 18x18 signed DSP multiplier (mult18x18_3c) between NREQ requesters.
- The multiplier is 3-cycle pipelined; its `en` input gates every internal register stage.
- This block does three things:
  - round-robin arbitrates operand requests;
  - tracks requester ID and valid through the pipeline;
  - stalls the whole pipeline with backpressure from a single result port.
- Sits between core/filter requesters and the multiplier instance, which this block instantiates.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must equal clog2(NREQ), minimum 1.
- LAT, 3, multiplier pipeline depth. Fixed by the DSP configuration; not to be overridden.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_valid  input  NREQ  per-requester operand valid
- req_ready  output  NREQ  per-requester accept; one-hot or zero
- req_a  input  18*NREQ  packed signed A operands; requester i at [18*i+17:18*i]
- req_b  input  18*NREQ  packed signed B operands, same packing
- res_valid  output  1  result valid
- res_ready  input  1  result consumer ready
- res_id  output  IDW  requester index of the current result
- res_p  output  36  signed product A*B
- stat_ops  output  32  completed-operation count (MULT_ARB_STATS_EN only, else 0)
- stat_stall  output  32  stall-cycle count (MULT_ARB_STATS_EN only, else 0)
- stat_clr  input  1  clears both stat counters (ignored without MULT_ARB_STATS_EN)

Behaviour:
- Pipeline enable:
  - `en = !(res_valid && !res_ready)`, driven to the multiplier `en`.
  - The multiplier `rst` is tied to `rst`.
  - All tag stages advance only when `en` = 1. Stall freezes every stage, including the output stage.
- Tag pipeline:
  - LAT stages of {valid, id}.
  - On an `en` cycle, stage0 loads {accept, gnt_id}; stage k loads stage k-1.
  - `res_valid` = stage[LAT-1].valid; `res_id` = stage[LAT-1].id; `res_p` = multiplier output.
- Arbitration:
  - Round-robin pointer `rr` (IDW bits).
  - Scan order: `rr`, `rr`+1, ... mod NREQ; the first asserted `req_valid` wins.
  - `req_ready[i]` = (i == winner) && `en` && !`rst`. All other bits are 0.
  - Accept = `req_valid[winner] && req_ready[winner]`. The winner's A/B are muxed to the multiplier in the same cycle.
  - On accept, `rr` <= winner+1 mod NREQ. With no accept, `rr` holds.
  - With no request, the multiplier inputs are driven 0 and stage0.valid loads 0 (a bubble).
- Latency and throughput:
  - Operand accepted at cycle t → result presented at t+3 with no stalls; each stall cycle adds one.
  - One accept per `en` cycle, so back-to-back throughput is 1 op/cycle.
  - `res_valid`/`res_id`/`res_p` stay stable while `res_valid` && !`res_ready`.
- Simultaneous events:
  - Accept and stall cannot coincide: `req_ready` is 0 whenever `en` = 0.
  - Result handshake and new accept in the same cycle are allowed; the pipeline shifts by one.
- Reset:
  - Takes effect on the next clk edge.
  - Clears all tag valid bits and ids, `rr` = 0, and the stat counters.
  - Multiplier registers reset, so `res_p` = 0 after reset.
  - Outputs after reset: `res_valid` = 0, `res_id` = 0, `res_p` = 0, `req_ready` = 0 while `rst` is high.
  - Reset mid-operation drops all in-flight ops silently; no result is emitted for them.
- Arithmetic:
  - Two's-complement 18x18 → 36-bit product, no rounding or saturation.
  - Example: -131072 * -131072 = 2^34.

Optional Feature:
- Macro: MULT_ARB_STATS_EN.
- Defined:
  - `stat_ops` increments on each result handshake (`res_valid` && `res_ready`).
  - `stat_stall` increments on each cycle with `en` = 0.
  - Both are 32-bit and wrap at 2^32.
  - `stat_clr` zeroes both next cycle; a clear wins over a same-cycle increment.
- Undefined: no counter logic, both stat outputs tied 0, `stat_clr` unused.

Test Plan:
- Single op: req0 A=3, B=-5, `res_ready`=1 → one cycle of `req_ready[0]`; 3 cycles later `res_valid`=1, `res_id`=0, `res_p`=-15 for exactly one cycle.
- Round-robin: all 4 requesters valid continuously, A=i+1, B=10 → grants in order 0,1,2,3,0,...; results 10, 20, 30, 40 with ids 0,1,2,3 on consecutive cycles.
- Backpressure: stream 4 ops, drop `res_ready` for 5 cycles while `res_valid`=1 → `res_p`/`res_id` held, `req_ready`=0 throughout; all 4 results later delivered in order with none lost or duplicated.
- Extremes: A=-131072, B=-131072 → `res_p`=36'h4_0000_0000; A=131071, B=-131072 → -17179738112.
- Reset mid-flight: accept 2 ops, assert `rst` one cycle → `res_valid` stays 0 afterwards, `rr`=0, so the next simultaneous req0+req2 grants 0 first.
- Stats (MULT_ARB_STATS_EN): 6 completed ops, 5 stall cycles → `stat_ops`=6, `stat_stall`=5; pulse `stat_clr` → both 0.
